// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter FSM encoding and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        ID_FETCH = 1'b0,
        ID_DATA  = 1'b1
    } req_id_t;

    localparam int RUN_W  = 4;
    localparam int WAIT_W = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; fetch is forced through after a run of data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_LATENCY  = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic        busy
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0);

    arb_state_t        r_state;
    arb_state_t        w_next;
    req_id_t           r_gnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;
    logic [RUN_W-1:0]  r_run;
    logic [WAIT_W-1:0] r_wait;

    logic w_idle;
    logic w_any;
    logic w_fetch_wins;
    logic w_grant;

    assign w_idle       = (r_state == IDLE);
    assign w_any        = if_req | d_req;
    assign w_fetch_wins = if_req & (~d_req | (r_run == RUN_MAX));
    assign w_grant      = w_idle & w_any;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = (RAM_LATENCY == 1) ? ACK : WAIT;
            WAIT:    if (r_wait == WAIT_LAST) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= ID_FETCH;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_run      <= '0;
            r_wait     <= '0;
        end else begin
            if (w_grant) begin
                r_gnt   <= w_fetch_wins ? ID_FETCH : ID_DATA;
                r_addr  <= w_fetch_wins ? if_addr : d_addr;
                r_we    <= ~w_fetch_wins & d_we;
                r_wdata <= d_wdata;
            end

            if (r_state == ISSUE)     r_wait <= '0;
            else if (r_state == WAIT) r_wait <= r_wait + 1'b1;

            if (r_state == ACK) begin
                if (r_gnt == ID_FETCH) r_if_rdata <= ram_q;
                else if (!r_we)        r_d_rdata  <= ram_q;
            end

            // Run length only matters while fetch is actually waiting.
            if (!if_req)
                r_run <= '0;
            else if (w_grant && w_fetch_wins)
                r_run <= '0;
            else if (w_grant && r_run != RUN_MAX)
                r_run <= r_run + 1'b1;
        end
    end

    assign if_ack     = (r_state == ACK) && (r_gnt == ID_FETCH);
    assign d_ack      = (r_state == ACK) && (r_gnt == ID_DATA);
    assign if_rdata   = if_ack ? ram_q : r_if_rdata;
    assign d_rdata    = (d_ack && !r_we) ? ram_q : r_d_rdata;
    assign d_misalign = d_ack && (r_addr[1:0] != 2'b00);
    assign ram_addr   = r_addr[31:2];
    assign ram_data   = r_wdata;
    assign ram_wren   = (r_state == ISSUE) && r_we;
    assign busy       = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at latency 1, one at 3.
module tb_mem_arbiter;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        if_req1, d_req1, d_we1;
    logic [31:0] if_addr1, d_addr1, d_wdata1;
    logic        if_ack1, d_ack1, d_misalign1, ram_wren1, busy1;
    logic [31:0] if_rdata1, d_rdata1, ram_data1, ram_q1;
    logic [29:0] ram_addr1;

    logic        if_req3, d_req3, d_we3;
    logic [31:0] if_addr3, d_addr3, d_wdata3;
    logic        if_ack3, d_ack3, d_misalign3, ram_wren3, busy3;
    logic [31:0] if_rdata3, d_rdata3, ram_data3, ram_q3;
    logic [29:0] ram_addr3;

    mem_arbiter #(.RAM_LATENCY(1), .MAX_DATA_RUN(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1),
        .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1),
        .d_wdata(d_wdata1), .d_ack(d_ack1), .d_rdata(d_rdata1),
        .d_misalign(d_misalign1),
        .ram_addr(ram_addr1), .ram_data(ram_data1),
        .ram_wren(ram_wren1), .ram_q(ram_q1), .busy(busy1)
    );

    mem_arbiter #(.RAM_LATENCY(3), .MAX_DATA_RUN(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3),
        .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3),
        .d_wdata(d_wdata3), .d_ack(d_ack3), .d_rdata(d_rdata3),
        .d_misalign(d_misalign3),
        .ram_addr(ram_addr3), .ram_data(ram_data3),
        .ram_wren(ram_wren3), .ram_q(ram_q3), .busy(busy3)
    );

    // RAM models, preloaded while reset is held
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [29:0] a1;
    logic [29:0] a3 [0:2];

    always @(posedge clk) begin
        if (reset) begin
            mem1[4]  <= 32'hDEADBEEF;
            mem1[16] <= 32'h11111111;
            mem1[17] <= 32'h22222222;
        end else if (ram_wren1) begin
            mem1[ram_addr1[5:0]] <= ram_data1;
        end
        a1 <= ram_addr1;
    end
    assign ram_q1 = mem1[a1[5:0]];

    always @(posedge clk) begin
        if (reset)          mem3[5] <= 32'hCAFEF00D;
        else if (ram_wren3) mem3[ram_addr3[5:0]] <= ram_data3;
        a3[0] <= ram_addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign ram_q3 = mem3[a3[2][5:0]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        n_checks++;
        $display("FAIL %s: event not seen (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (if_ack1 || d_ack1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL dut1_unexpected_ack: ack at cycle %0d, required none", cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1_ack_kind", d_ack1, e.is_data);
                chk("dut1_ack_cycle", cyc, e.cyc);
                if (e.is_data) begin
                    chk("dut1_d_rdata", d_rdata1, e.rdata);
                    chk("dut1_d_misalign", d_misalign1, e.mis);
                end else begin
                    chk("dut1_if_rdata", if_rdata1, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (if_ack3 || d_ack3) begin
            if (q3.size() == 0) begin
                n_checks++;
                $display("FAIL dut3_unexpected_ack: ack at cycle %0d, required none", cyc);
            end else begin
                e = q3.pop_front();
                chk("dut3_ack_kind", d_ack3, e.is_data);
                chk("dut3_ack_cycle", cyc, e.cyc);
                if (e.is_data) chk("dut3_d_rdata", d_rdata3, e.rdata);
                else           chk("dut3_if_rdata", if_rdata3, e.rdata);
            end
        end
    end

    // One latency-1 transaction; ack expected two cycles after launch.
    task automatic xact1(input logic is_data, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic mis);
        int k;
        int n;
        @(posedge clk); #1;
        k = cyc;
        if (is_data) begin
            d_req1 = 1'b1; d_we1 = we; d_addr1 = addr; d_wdata1 = wdata;
        end else begin
            if_req1 = 1'b1; if_addr1 = addr;
        end
        q1.push_back('{is_data, exp_data, mis, k + 2});
        @(negedge clk);
        @(negedge clk);
        chk("issue_ram_addr", {2'b00, ram_addr1}, {2'b00, addr[31:2]});
        chk("issue_ram_wren", ram_wren1, we);
        if (we) chk("issue_ram_data", ram_data1, wdata);
        n = 0;
        while (!(if_ack1 || d_ack1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) fail("dut1_ack_timeout");
        chk("ack_ram_wren", ram_wren1, 1'b0);
        chk("ack_ram_addr", {2'b00, ram_addr1}, {2'b00, addr[31:2]});
        @(posedge clk); #1;
        d_req1 = 1'b0;
        if_req1 = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int n;
        int nb;
        reset = 1'b1;
        {if_req1, d_req1, d_we1, if_req3, d_req3, d_we3} = '0;
        {if_addr1, d_addr1, d_wdata1} = '0;
        {if_addr3, d_addr3, d_wdata3} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {busy1, busy3}, 2'b00);
        chk("rst_acks", {if_ack1, d_ack1, if_ack3, d_ack3}, 4'b0);
        chk("rst_wren", {ram_wren1, ram_wren3, d_misalign1}, 3'b0);
        chk("rst_rdata1", if_rdata1 | d_rdata1, 32'h0);
        chk("rst_ram_addr", {2'b00, ram_addr1}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        xact1(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact1(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
        xact1(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        xact1(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 32'h12345678, 1'b0);
        xact1(1'b1, 1'b0, 32'h23, 32'h0, 32'h12345678, 1'b1);
        xact1(1'b1, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0);
        xact1(1'b0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);

        // Load withdrawn during ISSUE still completes
        @(posedge clk); #1;
        k = cyc;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h20;
        q1.push_back('{1'b1, 32'h12345678, 1'b0, k + 2});
        @(posedge clk); #1;
        d_req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Both requesters held: D,D,D,D,F twice
        @(posedge clk); #1;
        k = cyc;
        if_req1 = 1'b1; if_addr1 = 32'h40;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h44;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 != 4)
                q1.push_back('{1'b1, 32'h22222222, 1'b0, k + 2 + 3 * i});
            else
                q1.push_back('{1'b0, 32'h11111111, 1'b0, k + 2 + 3 * i});
        end
        n = 0;
        nb = 0;
        while (n < 10 && nb < 60) begin
            @(negedge clk);
            nb++;
            if (if_ack1 || d_ack1) n++;
        end
        if (n < 10) fail("dut1_burst_timeout");
        @(posedge clk); #1;
        if_req1 = 1'b0;
        d_req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Latency 3 load: busy for four cycles, ack four after launch
        @(posedge clk); #1;
        k = cyc;
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h14;
        q3.push_back('{1'b1, 32'hCAFEF00D, 1'b0, k + 4});
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy3) nb++;
            if (d_ack3) d_req3 = 1'b0;
        end
        chk("dut3_busy_cycles", nb, 4);
        chk("dut3_d_rdata_held", d_rdata3, 32'hCAFEF00D);

        // Reset while in WAIT aborts the load
        @(posedge clk); #1;
        d_req3 = 1'b1; d_addr3 = 32'h14;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("dut3_busy_in_wait", busy3, 1'b1);
        reset = 1'b1;
        d_req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_busy", busy3, 1'b0);
        chk("rst_wait_ack", {if_ack3, d_ack3}, 2'b00);
        chk("rst_wait_d_rdata", d_rdata3, 32'h0);
        chk("rst_wait_if_rdata", if_rdata3, 32'h0);
        chk("rst_d_rdata1", d_rdata1, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_ack3 || if_ack3) n++;
        end
        chk("no_ack_after_reset", n, 0);

        chk("dut1_queue_empty", q1.size(), 0);
        chk("dut3_queue_empty", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
